// File: rtl/peri_pkg.sv
// Shared periphery definitions: readout FSM encoding and default geometry
// of the column_pixel_peri FIFO interface.
package peri_pkg;

  localparam int unsigned PERI_N_COL  = 8;
  localparam int unsigned PERI_DATA_W = 28;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational circular priority encoder: first set req bit after base,
// scanning base+1 .. base+N (mod N). N must be a power of two.
module rr_pick #(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] base,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = base;
    cand  = base;
    for (int unsigned k = 1; k <= N; k++) begin
      // Truncation to IDX_W bits performs the modulo-N wrap.
      cand = base + IDX_W'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/peri_readout_arbiter.sv
// Round-robin readout arbiter: polls column FIFOs, pops up to BURST words
// per grant and forwards {column, word} on a single valid/ready output.
module peri_readout_arbiter
  import peri_pkg::*;
#(
  parameter int unsigned N_COL  = PERI_N_COL,
  parameter int unsigned DATA_W = PERI_DATA_W,
  parameter int unsigned BURST  = 4,
  parameter int unsigned IDX_W  = $clog2(N_COL)
) (
  input  logic                      clk_40MHz,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [N_COL-1:0]          empty,
  input  logic [N_COL*DATA_W-1:0]   fifo_data,
  output logic [N_COL-1:0]          shakehands_next,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [IDX_W+DATA_W-1:0]   out_data,
  output logic                      busy,
  output logic [15:0]               word_cnt
);

  localparam int unsigned BURST_W = 4;

  arb_state_t          state_q, state_d;
  logic [IDX_W-1:0]    gnt_q, gnt_d;
  logic [BURST_W-1:0]  burst_q, burst_d;
  logic [N_COL-1:0]    shk_d;
  logic [15:0]         cnt_q;
  logic                pick_found;
  logic [IDX_W-1:0]    pick_idx;
  logic                slot_free;
  logic [DATA_W-1:0]   col_word [N_COL];

  always_comb begin
    for (int unsigned i = 0; i < N_COL; i++) begin
      col_word[i] = fifo_data[i*DATA_W +: DATA_W];
    end
  end

  rr_pick #(
    .N     (N_COL),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (~empty),
    .base  (gnt_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign slot_free = !out_valid || out_ready;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    burst_d = burst_q;
    shk_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (enable && pick_found && slot_free) begin
          gnt_d           = pick_idx;
          shk_d[pick_idx] = 1'b1;
          burst_d         = '0;
          state_d         = ST_POP;
        end
      end
      ST_POP: begin
        burst_d = burst_q + 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (enable && !empty[gnt_q] && (burst_q < BURST_W'(BURST)) && slot_free) begin
          shk_d[gnt_q] = 1'b1;
          state_d      = ST_POP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_40MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      gnt_q           <= IDX_W'(N_COL - 1);
      burst_q         <= '0;
      shakehands_next <= '0;
    end else begin
      state_q         <= state_d;
      gnt_q           <= gnt_d;
      burst_q         <= burst_d;
      shakehands_next <= shk_d;
    end
  end

  // A POP load takes priority over the handshake clear so back-to-back words keep out_valid high.
  always_ff @(posedge clk_40MHz or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      cnt_q     <= '0;
    end else begin
      if (state_q == ST_POP) begin
        out_valid <= 1'b1;
        out_data  <= {gnt_q, col_word[gnt_q]};
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (out_valid && out_ready && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  assign word_cnt = cnt_q;
  assign busy     = (state_q != ST_IDLE) || out_valid;

endmodule
